// File: rtl/pool_window_gen.sv
// pool_window_gen: raster-order FP16 pixel stream to stride-aligned 3x3
// windows for the max-pool stage. Two line buffers plus a 3x3 register
// window; each aligned window is issued once and the input stalls until
// the pool stage reports completion.
//
// Optional watchdog: define POOL_WIN_WDT_EN to re-issue a window whose
// completion never arrives within WDT_CYCLES and raise sticky wdt_err.
//
// state  | meaning
// -------+-------------------------------------------------------------
// FILL   | accepting pixels, shifting window, waiting for aligned window
// ISSUE  | one-cycle pool start pulse, window frozen
// WAIT   | window frozen, waiting for pool completion edge
module pool_window_gen #(
    parameter int IMG_W      = 16,
    parameter int IMG_H      = 16,
    parameter int STRIDE     = 2,
    parameter int WDT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [15:0]  in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [143:0] im,
    output logic         pool_ready,
    input  logic         pool_valid,
    output logic         frame_done,
    output logic         wdt_err
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic [1:0] {S_FILL, S_ISSUE, S_WAIT} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [RW-1:0]  r_row;
    logic [CW-1:0]  r_col;
    logic [15:0]    r_win   [3][3];
    logic [15:0]    r_line0 [IMG_W];
    logic [15:0]    r_line1 [IMG_W];
    logic           r_last_win;
    logic           r_pool_valid_q;
    logic           r_done_pend;
    logic           w_done_pend_nxt;
    logic           w_accept;
    logic           w_win_cond;
    logic           w_last_col;
    logic           w_last_row;
    logic           w_done_edge;
    logic           w_leave_wait;
    logic [143:0]   w_im;

    assign w_accept    = in_valid & in_ready;
    assign w_last_col  = (r_col == CW'(IMG_W - 1));
    assign w_last_row  = (r_row == RW'(IMG_H - 1));
    assign w_done_edge = pool_valid & ~r_pool_valid_q;

    // Stride alignment: with STRIDE 2, (n-2) is even exactly when n is even.
    assign w_win_cond = (r_row >= RW'(2)) && (r_col >= CW'(2)) &&
                        ((STRIDE == 1) || (!r_row[0] && !r_col[0]));

    // Window/line-buffer shift and raster counters, advanced on each accepted pixel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_row      <= '0;
            r_col      <= '0;
            r_last_win <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
            for (int i = 0; i < IMG_W; i++) begin
                r_line0[i] <= '0;
                r_line1[i] <= '0;
            end
        end else if (w_accept) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= r_win[r][2];
            end
            r_win[0][2]    <= r_line0[r_col];
            r_win[1][2]    <= r_line1[r_col];
            r_win[2][2]    <= in_data;
            r_line0[r_col] <= r_line1[r_col];
            r_line1[r_col] <= in_data;
            if (w_win_cond) begin
                r_last_win <= w_last_col && w_last_row;
            end
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Pack the register window into the 144-bit word, element k = 3*row + col
    always_comb begin
        w_im = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w_im[16*(3*r+c) +: 16] = r_win[r][c];
            end
        end
    end

    assign im = w_im;

`ifdef POOL_WIN_WDT_EN
    localparam int WDW = $clog2(WDT_CYCLES + 1);

    logic [WDW-1:0] r_wdt_cnt;
    logic           r_wdt_err;
    logic           w_wdt_fire;

    // Watchdog down-counter: loaded on ISSUE, terminal count after WDT_CYCLES WAIT cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wdt_cnt <= '0;
            r_wdt_err <= 1'b0;
        end else begin
            if (r_state == S_ISSUE) begin
                r_wdt_cnt <= WDW'(WDT_CYCLES - 1);
            end else if ((r_state == S_WAIT) && (r_wdt_cnt != '0)) begin
                r_wdt_cnt <= r_wdt_cnt - WDW'(1);
            end
            if (w_wdt_fire) begin
                r_wdt_err <= 1'b1;
            end
        end
    end

    assign wdt_err = r_wdt_err;
`else
    assign wdt_err = 1'b0;
`endif

    // FSM state register plus completion-edge tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_FILL;
            r_pool_valid_q <= 1'b0;
            r_done_pend    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_pool_valid_q <= pool_valid;
            r_done_pend    <= w_done_pend_nxt;
        end
    end

    // FSM next-state; a done edge seen during ISSUE is held for the first WAIT cycle
    always_comb begin
        w_state_nxt     = r_state;
        w_done_pend_nxt = r_done_pend;
        w_leave_wait    = 1'b0;
`ifdef POOL_WIN_WDT_EN
        w_wdt_fire      = 1'b0;
`endif
        case (r_state)
            S_FILL: begin
                if (w_accept && w_win_cond) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_done_edge) begin
                    w_done_pend_nxt = 1'b1;
                end
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_done_edge || r_done_pend) begin
                    w_leave_wait    = 1'b1;
                    w_done_pend_nxt = 1'b0;
                    w_state_nxt     = S_FILL;
                end
`ifdef POOL_WIN_WDT_EN
                else if (r_wdt_cnt == '0) begin
                    w_wdt_fire  = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
`endif
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    assign in_ready   = rst_n && (r_state == S_FILL);
    assign pool_ready = rst_n && (r_state == S_ISSUE);
    assign frame_done = rst_n && w_leave_wait && r_last_win;

endmodule

// File: tb/tb_pool_window_gen.sv
// Bench for pool_window_gen: two 5x5 instances (stride 2 and stride 1),
// directed pixel streams 0..24 with hand-derived window contents.
module tb_pool_window_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [1:0]   in_valid;
    logic [1:0]   in_ready;
    logic [1:0]   pool_ready;
    logic [1:0]   pool_valid;
    logic [1:0]   frame_done;
    logic [1:0]   wdt_err;
    logic [15:0]  in_data [2];
    logic [143:0] im [2];

    logic [1:0]   pv_seq = 2'b00;
    logic [1:0]   imm    = 2'b00;
    int           dly [2]       = '{0, 0};
    int           starts [2]    = '{0, 0};
    int           ign_until [2] = '{0, 0};

    int           n_err = 0;
    int           n_chk = 0;
    logic [143:0] win_log [2][16];
    int           win_n [2]   = '{0, 0};
    int           fd_n [2]    = '{0, 0};
    int           rdy_bad [2] = '{0, 0};
    int           wl [2]      = '{0, 0};
    int           max_wl [2]  = '{0, 0};
    logic         in_wait [2] = '{1'b0, 1'b0};
    int           exp_c [16];

    pool_window_gen #(.IMG_W(5), .IMG_H(5), .STRIDE(2), .WDT_CYCLES(10)) u_dut_s2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data[0]),
        .in_valid   (in_valid[0]),
        .in_ready   (in_ready[0]),
        .im         (im[0]),
        .pool_ready (pool_ready[0]),
        .pool_valid (pool_valid[0]),
        .frame_done (frame_done[0]),
        .wdt_err    (wdt_err[0])
    );

    pool_window_gen #(.IMG_W(5), .IMG_H(5), .STRIDE(1), .WDT_CYCLES(10)) u_dut_s1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data[1]),
        .in_valid   (in_valid[1]),
        .in_ready   (in_ready[1]),
        .im         (im[1]),
        .pool_ready (pool_ready[1]),
        .pool_valid (pool_valid[1]),
        .frame_done (frame_done[1]),
        .wdt_err    (wdt_err[1])
    );

    // Pool stage model: one-cycle completion 8 cycles after start, or same-cycle in imm mode
    assign pool_valid[0] = imm[0] ? pool_ready[0] : pv_seq[0];
    assign pool_valid[1] = imm[1] ? pool_ready[1] : pv_seq[1];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            pv_seq[d] <= 1'b0;
            if (pool_ready[d]) begin
                starts[d] <= starts[d] + 1;
                if (!imm[d] && starts[d] >= ign_until[d]) dly[d] <= 8;
            end else if (dly[d] > 0) begin
                dly[d] <= dly[d] - 1;
                if (dly[d] == 1) pv_seq[d] <= 1'b1;
            end
        end
    end

    // Capture issued windows, stall behaviour and frame_done pulses
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                in_wait[d] = 1'b0;
            end else if (pool_ready[d]) begin
                if (win_n[d] < 16) win_log[d][win_n[d]] = im[d];
                win_n[d]++;
                if (in_ready[d]) rdy_bad[d]++;
                in_wait[d] = 1'b1;
                wl[d] = 0;
            end else if (in_wait[d]) begin
                if (in_ready[d]) begin
                    in_wait[d] = 1'b0;
                    if (wl[d] > max_wl[d]) max_wl[d] = wl[d];
                end else begin
                    wl[d]++;
                end
            end
            if (frame_done[d]) fd_n[d]++;
        end
    end

    task automatic check_val(input string tag, input logic [143:0] got, input logic [143:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs(input int d);
        win_n[d]   = 0;
        fd_n[d]    = 0;
        rdy_bad[d] = 0;
        max_wl[d]  = 0;
    endtask

    // Entered and left at posedge+1; in_ready is stable for the whole cycle
    task automatic feed(input int d, input int n, input bit gaps);
        int idx = 0;
        int guard = 0;
        bit acc;
        while (idx < n && guard < 4000) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                in_valid[d] = 1'b0;
            end else begin
                in_valid[d] = 1'b1;
                in_data[d]  = 16'(idx);
            end
            #1;
            acc = in_valid[d] & in_ready[d];
            @(posedge clk);
            #1;
            if (acc) idx++;
            guard++;
        end
        in_valid[d] = 1'b0;
        check_val("pixels_accepted", idx, n);
    endtask

    task automatic wait_frame(input int d, input int target);
        int g = 0;
        while (fd_n[d] < target && g < 600) begin
            @(posedge clk);
            g++;
        end
        repeat (12) @(posedge clk);
        #1;
        check_val("frame_done_count", fd_n[d], target);
    endtask

    // Window centred on pixel index ctr holds ctr-6 + 5*row + col
    task automatic check_windows(input int d, input int n);
        logic [143:0] e;
        check_val($sformatf("window_count_d%0d", d), win_n[d], n);
        for (int i = 0; i < n; i++) begin
            e = '0;
            for (int k = 0; k < 9; k++) begin
                e[16*k +: 16] = 16'(exp_c[i] - 6 + 5 * (k / 3) + (k % 3));
            end
            check_val($sformatf("window_d%0d_%0d", d, i), win_log[d][i], e);
        end
        check_val($sformatf("in_ready_in_issue_d%0d", d), rdy_bad[d], 0);
    endtask

    task automatic set_s2_centres();
        exp_c[0] = 6; exp_c[1] = 8; exp_c[2] = 16; exp_c[3] = 18;
    endtask

    initial begin
        logic [143:0] w0;
        rst_n       = 1'b0;
        in_valid    = 2'b00;
        in_data[0]  = '0;
        in_data[1]  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready", in_ready, 2'b00);
        check_val("rst_pool_ready", pool_ready, 2'b00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("post_rst_in_ready", in_ready, 2'b11);
        check_val("post_rst_im", im[0], '0);
        check_val("post_rst_pool_ready", pool_ready, 2'b00);
        check_val("post_rst_frame_done", frame_done, 2'b00);
        check_val("post_rst_wdt_err", wdt_err, 2'b00);

        // Stride 2, continuous input
        clear_logs(0);
        feed(0, 25, 1'b0);
        wait_frame(0, 1);
        set_s2_centres();
        check_windows(0, 4);
        w0 = win_log[0][0];
        check_val("win1_elem0", w0[15:0], 16'd0);
        check_val("win1_elem8", w0[143:128], 16'd12);
        check_val("s2_wait_len", max_wl[0], 9);

        // Stride 2, random input gaps
        clear_logs(0);
        feed(0, 25, 1'b1);
        wait_frame(0, 1);
        check_windows(0, 4);

        // Completion edge in the ISSUE cycle
        imm[0] = 1'b1;
        clear_logs(0);
        feed(0, 25, 1'b0);
        wait_frame(0, 1);
        check_windows(0, 4);
        check_val("imm_wait_len", max_wl[0], 1);
        imm[0] = 1'b0;

        // Stride 1
        clear_logs(1);
        feed(1, 25, 1'b0);
        wait_frame(1, 1);
        exp_c[0] = 6;  exp_c[1] = 7;  exp_c[2] = 8;
        exp_c[3] = 11; exp_c[4] = 12; exp_c[5] = 13;
        exp_c[6] = 16; exp_c[7] = 17; exp_c[8] = 18;
        check_windows(1, 9);

        // Reset after 9 pixels, then replay the plane
        clear_logs(0);
        feed(0, 9, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_val("no_early_window", win_n[0], 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        feed(0, 25, 1'b0);
        wait_frame(0, 1);
        set_s2_centres();
        check_windows(0, 4);

`ifdef POOL_WIN_WDT_EN
        // First start ignored: watchdog re-issues the same window
        clear_logs(0);
        ign_until[0] = starts[0] + 1;
        feed(0, 25, 1'b0);
        wait_frame(0, 1);
        exp_c[0] = 6; exp_c[1] = 6; exp_c[2] = 8; exp_c[3] = 16; exp_c[4] = 18;
        check_windows(0, 5);
        check_val("wdt_err_set", wdt_err[0], 1'b1);
`else
        check_val("wdt_err_tied", wdt_err, 2'b00);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
